wb_buffer: RTL and testbench
============================

WB_BUFFER -- requirements
Module: wb_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning write-back queue entries (power of two, 2..16).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset (one clock, reset synchronous and active-high).
REQ-004 SHALL have ports ex_valid (in, 1), ex_dest (in, 5), ex_val (in, 32), ex_ready (out, 1): execute-stage result request.
REQ-005 SHALL have ports mem_valid (in, 1), mem_dest (in, 5), mem_val (in, 32), mem_ready (out, 1): memory-stage result request.
REQ-006 SHALL have ports write_enable (out, 1), dest (out, 5), destVal (out, 32): register-file write port drive.
REQ-007 SHALL have ports source1 (in, 5), source2 (in, 5): register numbers being read this cycle.
REQ-008 SHALL have ports fwd1_hit (out, 1), fwd1_val (out, 32), fwd2_hit (out, 1), fwd2_val (out, 32): forwarding results.
REQ-009 SHALL have ports empty (out, 1) and count (out, clog2(DEPTH)+1): queue occupancy.

Function
REQ-010 SHALL hold a circular FIFO of {dest, val} entries with head/tail pointers wrapping modulo DEPTH and an occupancy counter.
REQ-011 SHALL compute free = DEPTH - count from registered state only; dequeue in the same cycle SHALL NOT add to free (no pass-through).
REQ-012 SHALL drive mem_ready = (free >= 1), combinationally.
REQ-013 SHALL drive ex_ready = (free >= 2) or (free >= 1 and not mem_valid).
REQ-014 SHALL treat a request as accepted on a rising edge where valid and ready are both high.
REQ-015 SHALL enqueue both accepted requests in one cycle, mem entry first (older), ex entry second.
REQ-016 SHALL accept but never enqueue a request whose dest is 0; it consumes no slot, and ex_ready SHALL treat a mem request with mem_dest = 0 as not consuming a slot.
REQ-017 SHALL dequeue the head entry each cycle count > 0, registering write_enable = 1, dest = head dest, destVal = head val for the following cycle.
REQ-018 SHALL register write_enable = 0, dest and destVal held, in any cycle count = 0 at the edge.
REQ-019 SHALL give latency: request accepted at edge N into an empty queue -> write_enable high during cycle after edge N+1.
REQ-020 SHALL update count as count + enqueued - dequeued each edge; count never exceeds DEPTH nor underflows.
REQ-021 SHALL set fwdK_hit = 1 when sourceK != 0 and sourceK matches a queued entry or the registered output (write_enable = 1 and dest = sourceK).
REQ-022 SHALL select fwdK_val from the youngest match: queue entries nearest tail first, the output register last.
REQ-023 SHALL drive fwdK_hit = 0 and fwdK_val = 0 when no match or sourceK = 0; forwarding is combinational.
REQ-024 SHALL NOT forward values of requests being accepted in the current cycle.
REQ-025 SHALL drive empty = (count = 0).

Reset
REQ-026 SHALL, on reset high at a rising edge, clear head, tail, count, write_enable, dest and destVal to 0, discarding queued entries.
REQ-027 SHALL ignore valid inputs on a reset edge; ready outputs reflect the cleared state in the next cycle (mem_ready = ex_ready = 1).
REQ-028 SHALL NOT require entry storage to be reset; data of empty slots SHALL never be observable on outputs.

Verification
REQ-029 SHALL cover: after reset, mem (dest 5, 0x11111111) and ex (dest 6, 0x22222222) in the same cycle -> writes r5 then r6 on consecutive cycles, count 2 -> 1 -> 0.
REQ-030 SHALL cover: ex-only stream of DEPTH+2 requests with drain -> ex_ready drops only when free < 1, no entry lost or reordered, the wrap-around of pointers is exercised.
REQ-031 SHALL cover: count = DEPTH-1 with both valid -> mem accepted, ex_ready = 0, ex accepted next cycle.
REQ-032 SHALL cover: queued r3 = 0xA then r3 = 0xB, source1 = 3 -> fwd1_hit = 1, fwd1_val = 0xB; source2 = 0 -> fwd2_hit = 0.
REQ-033 SHALL cover: mem_dest = 0 request -> mem_ready handshake completes, count unchanged, no write_enable pulse.
REQ-034 SHALL cover: reset asserted with 3 entries queued -> next cycle count = 0, empty = 1, write_enable = 0, fwd hits = 0.

Source files
------------

// File: rtl/wb_buffer.sv
// Write-back buffer: queues execute/memory results, retires one per cycle to the
// register-file write port and forwards the youngest pending value to operand reads.
module wb_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    ex_valid,
    input  logic [4:0]              ex_dest,
    input  logic [31:0]             ex_val,
    output logic                    ex_ready,

    input  logic                    mem_valid,
    input  logic [4:0]              mem_dest,
    input  logic [31:0]             mem_val,
    output logic                    mem_ready,

    output logic                    write_enable,
    output logic [4:0]              dest,
    output logic [31:0]             destVal,

    input  logic [4:0]              source1,
    input  logic [4:0]              source2,
    output logic                    fwd1_hit,
    output logic [31:0]             fwd1_val,
    output logic                    fwd2_hit,
    output logic [31:0]             fwd2_val,

    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    // Entry storage carries no reset; only slots inside [head, head+count) are ever read.
    logic [4:0]    ent_dest [DEPTH];
    logic [31:0]   ent_val  [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW-1:0] ex_slot;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] free;

    logic          we_q, we_d;
    logic [4:0]    dest_q, dest_d;
    logic [31:0]   val_q, val_d;

    logic          mem_takes_slot;
    logic          mem_acc, ex_acc;
    logic          mem_enq, ex_enq;
    logic          deq;

    // Handshake and queue bookkeeping
    always_comb begin
        free           = CW'(DEPTH) - count_q;
        mem_takes_slot = mem_valid && (mem_dest != 5'd0);
        mem_ready      = (free >= CW'(1));
        ex_ready       = (free >= CW'(2)) || ((free >= CW'(1)) && !mem_takes_slot);

        mem_acc = mem_valid && mem_ready;
        ex_acc  = ex_valid && ex_ready;
        mem_enq = mem_acc && (mem_dest != 5'd0);
        ex_enq  = ex_acc && (ex_dest != 5'd0);
        deq     = (count_q != '0);

        // The mem entry is older, so it takes the tail slot when both enqueue.
        ex_slot = mem_enq ? (tail_q + PW'(1)) : tail_q;
        tail_d  = tail_q + PW'(mem_enq) + PW'(ex_enq);
        head_d  = head_q + PW'(deq);
        count_d = count_q + CW'(mem_enq) + CW'(ex_enq) - CW'(deq);
    end

    // Register-file write port: retire the head entry, otherwise hold dest/value.
    always_comb begin
        we_d   = 1'b0;
        dest_d = dest_q;
        val_d  = val_q;
        if (deq) begin
            we_d   = 1'b1;
            dest_d = ent_dest[head_q];
            val_d  = ent_val[head_q];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (mem_enq) begin
                ent_dest[tail_q] <= mem_dest;
                ent_val[tail_q]  <= mem_val;
            end
            if (ex_enq) begin
                ent_dest[ex_slot] <= ex_dest;
                ent_val[ex_slot]  <= ex_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            dest_q  <= '0;
            val_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            we_q    <= we_d;
            dest_q  <= dest_d;
            val_q   <= val_d;
        end
    end

    // Forwarding: scan from the output register through the queue oldest-to-youngest,
    // letting each later match override, so the youngest value wins.
    always_comb begin
        logic [PW-1:0] idx;
        fwd1_hit = 1'b0;
        fwd1_val = '0;
        fwd2_hit = 1'b0;
        fwd2_val = '0;
        idx      = '0;

        if (we_q && (dest_q == source1)) begin
            fwd1_hit = 1'b1;
            fwd1_val = val_q;
        end
        if (we_q && (dest_q == source2)) begin
            fwd2_hit = 1'b1;
            fwd2_val = val_q;
        end

        for (int i = 0; i < int'(DEPTH); i++) begin
            idx = head_q + PW'(i);
            if (CW'(i) < count_q) begin
                if (ent_dest[idx] == source1) begin
                    fwd1_hit = 1'b1;
                    fwd1_val = ent_val[idx];
                end
                if (ent_dest[idx] == source2) begin
                    fwd2_hit = 1'b1;
                    fwd2_val = ent_val[idx];
                end
            end
        end

        // Register 0 is never forwarded.
        if (source1 == 5'd0) begin
            fwd1_hit = 1'b0;
            fwd1_val = '0;
        end
        if (source2 == 5'd0) begin
            fwd2_hit = 1'b0;
            fwd2_val = '0;
        end
    end

    assign write_enable = we_q;
    assign dest         = dest_q;
    assign destVal      = val_q;
    assign count        = count_q;
    assign empty        = (count_q == '0);

endmodule

// File: tb/tb_wb_buffer.sv
// Self-checking bench for wb_buffer: directed scenarios followed by random traffic,
// all compared against a queue-based reference model.
module tb_wb_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          ex_valid, mem_valid;
    logic [4:0]    ex_dest, mem_dest;
    logic [31:0]   ex_val, mem_val;
    logic          ex_ready, mem_ready;
    logic          write_enable;
    logic [4:0]    dest;
    logic [31:0]   destVal;
    logic [4:0]    source1, source2;
    logic          fwd1_hit, fwd2_hit;
    logic [31:0]   fwd1_val, fwd2_val;
    logic          empty;
    logic [CW-1:0] count;

    wb_buffer #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .ex_valid     (ex_valid),
        .ex_dest      (ex_dest),
        .ex_val       (ex_val),
        .ex_ready     (ex_ready),
        .mem_valid    (mem_valid),
        .mem_dest     (mem_dest),
        .mem_val      (mem_val),
        .mem_ready    (mem_ready),
        .write_enable (write_enable),
        .dest         (dest),
        .destVal      (destVal),
        .source1      (source1),
        .source2      (source2),
        .fwd1_hit     (fwd1_hit),
        .fwd1_val     (fwd1_val),
        .fwd2_hit     (fwd2_hit),
        .fwd2_val     (fwd2_val),
        .empty        (empty),
        .count        (count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  d;
        logic [31:0] v;
    } ent_t;

    // Reference model: pending entries in age order plus the write-port register.
    ent_t        mq[$];
    logic        m_we;
    logic [4:0]  m_dest;
    logic [31:0] m_val;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int m_free();
        return int'(DEPTH) - mq.size();
    endfunction

    function automatic logic m_mem_ready();
        return m_free() >= 1;
    endfunction

    function automatic logic m_ex_ready(input logic mv, input logic [4:0] md);
        int f = m_free();
        return (f >= 2) || ((f >= 1) && !(mv && (md != 5'd0)));
    endfunction

    function automatic logic [32:0] m_fwd(input logic [4:0] s);
        if (s == 5'd0) return '0;
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].d == s) return {1'b1, mq[i].v};
        if (m_we && (m_dest == s)) return {1'b1, m_val};
        return '0;
    endfunction

    // Apply inputs just after a falling edge and compare every output with the model.
    task automatic drive(input logic rst, input logic mv, input logic [4:0] md,
                         input logic [31:0] mvl, input logic ev, input logic [4:0] ed,
                         input logic [31:0] evl, input logic [4:0] s1, input logic [4:0] s2);
        logic [32:0] f1, f2;
        reset     = rst;
        mem_valid = mv;
        mem_dest  = md;
        mem_val   = mvl;
        ex_valid  = ev;
        ex_dest   = ed;
        ex_val    = evl;
        source1   = s1;
        source2   = s2;
        #1;
        f1 = m_fwd(s1);
        f2 = m_fwd(s2);
        chk("mem_ready", 32'(mem_ready), 32'(m_mem_ready()));
        chk("ex_ready", 32'(ex_ready), 32'(m_ex_ready(mv, md)));
        chk("write_enable", 32'(write_enable), 32'(m_we));
        chk("dest", 32'(dest), 32'(m_dest));
        chk("destVal", destVal, m_val);
        chk("count", 32'(count), mq.size());
        chk("empty", 32'(empty), 32'(mq.size() == 0));
        chk("fwd1_hit", 32'(fwd1_hit), 32'(f1[32]));
        chk("fwd1_val", fwd1_val, f1[31:0]);
        chk("fwd2_hit", 32'(fwd2_hit), 32'(f2[32]));
        chk("fwd2_val", fwd2_val, f2[31:0]);
    endtask

    task automatic idle(input logic [4:0] s1, input logic [4:0] s2);
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, s1, s2);
    endtask

    // Advance one clock and apply the same edge to the model.
    task automatic tick();
        logic macc, eacc;
        ent_t e;
        macc = mem_valid && m_mem_ready();
        eacc = ex_valid && m_ex_ready(mem_valid, mem_dest);
        @(posedge clk);
        if (reset) begin
            mq.delete();
            m_we   = 1'b0;
            m_dest = '0;
            m_val  = '0;
        end else begin
            if (mq.size() > 0) begin
                e      = mq.pop_front();
                m_we   = 1'b1;
                m_dest = e.d;
                m_val  = e.v;
            end else begin
                m_we = 1'b0;
            end
            if (macc && (mem_dest != 5'd0)) mq.push_back(ent_t'({mem_dest, mem_val}));
            if (eacc && (ex_dest != 5'd0)) mq.push_back(ent_t'({ex_dest, ex_val}));
        end
        @(negedge clk);
    endtask

    task automatic drain();
        for (int k = 0; k < int'(DEPTH) + 3; k++) begin
            idle(5'd0, 5'd0);
            tick();
        end
    endtask

    initial begin
        reset     = 1'b1;
        mem_valid = 1'b0;
        mem_dest  = '0;
        mem_val   = '0;
        ex_valid  = 1'b0;
        ex_dest   = '0;
        ex_val    = '0;
        source1   = '0;
        source2   = '0;
        m_we      = 1'b0;
        m_dest    = '0;
        m_val     = '0;
        tick();

        // Reset state
        idle(5'd0, 5'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_we", 32'(write_enable), 32'd0);
        tick();

        // Simultaneous mem/ex: r5 then r6 retire on consecutive cycles
        drive(1'b0, 1'b1, 5'd5, 32'h1111_1111, 1'b1, 5'd6, 32'h2222_2222, 5'd0, 5'd0);
        chk("pair_ex_ready", 32'(ex_ready), 32'd1);
        tick();
        chk("pair_count2", 32'(count), 32'd2);
        idle(5'd0, 5'd0);
        tick();
        chk("pair_we1", 32'(write_enable), 32'd1);
        chk("pair_dest5", 32'(dest), 32'd5);
        chk("pair_val5", destVal, 32'h1111_1111);
        chk("pair_count1", 32'(count), 32'd1);
        idle(5'd0, 5'd0);
        tick();
        chk("pair_dest6", 32'(dest), 32'd6);
        chk("pair_val6", destVal, 32'h2222_2222);
        chk("pair_count0", 32'(count), 32'd0);
        idle(5'd0, 5'd0);
        tick();
        chk("pair_we0", 32'(write_enable), 32'd0);

        // Ex-only stream longer than the queue, wrapping the pointers
        for (int i = 0; i < int'(DEPTH) + 2; i++) begin
            drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(i % 7 + 1), $urandom, 5'(i % 7 + 1), 5'd0);
            tick();
        end
        drain();

        // Fill to DEPTH-1, then both valid: only mem fits this cycle
        for (int k = 0; k < 8 && mq.size() < int'(DEPTH) - 1; k++) begin
            drive(1'b0, 1'b1, 5'(2 * k + 8), $urandom, 1'b1, 5'(2 * k + 9), $urandom, 5'd0, 5'd0);
            tick();
        end
        chk("fill_level", 32'(count), DEPTH - 1);
        drive(1'b0, 1'b1, 5'd20, 32'hAAAA_0001, 1'b1, 5'd21, 32'hAAAA_0002, 5'd21, 5'd20);
        chk("full_mem_ready", 32'(mem_ready), 32'd1);
        chk("full_ex_ready", 32'(ex_ready), 32'd0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd21, 32'hAAAA_0002, 5'd21, 5'd20);
        chk("retry_ex_ready", 32'(ex_ready), 32'd1);
        tick();
        drain();

        // Two pending writes to r3: youngest value forwards
        drive(1'b0, 1'b1, 5'd3, 32'hA, 1'b1, 5'd3, 32'hB, 5'd3, 5'd0);
        chk("same_cycle_nofwd", 32'(fwd1_hit), 32'd0);
        tick();
        idle(5'd3, 5'd0);
        chk("fwd_r3_hit", 32'(fwd1_hit), 32'd1);
        chk("fwd_r3_val", fwd1_val, 32'hB);
        chk("fwd_r0_hit", 32'(fwd2_hit), 32'd0);
        tick();
        for (int k = 0; k < 3; k++) begin
            idle(5'd3, 5'd0);
            tick();
        end

        // Mem request to r0: handshake completes, nothing queued or written
        drive(1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        chk("r0_mem_ready", 32'(mem_ready), 32'd1);
        tick();
        chk("r0_count", 32'(count), 32'd0);
        idle(5'd0, 5'd0);
        tick();
        chk("r0_no_we", 32'(write_enable), 32'd0);

        // Reset with three entries queued
        drive(1'b0, 1'b1, 5'd10, 32'h10, 1'b1, 5'd11, 32'h11, 5'd0, 5'd0);
        tick();
        drive(1'b0, 1'b1, 5'd12, 32'h12, 1'b1, 5'd13, 32'h13, 5'd0, 5'd0);
        tick();
        chk("pre_rst_count", 32'(count), 32'd3);
        drive(1'b1, 1'b1, 5'd14, 32'h14, 1'b1, 5'd15, 32'h15, 5'd12, 5'd13);
        tick();
        idle(5'd12, 5'd11);
        chk("post_rst_count", 32'(count), 32'd0);
        chk("post_rst_empty", 32'(empty), 32'd1);
        chk("post_rst_we", 32'(write_enable), 32'd0);
        chk("post_rst_fwd1", 32'(fwd1_hit), 32'd0);
        chk("post_rst_fwd2", 32'(fwd2_hit), 32'd0);
        chk("post_rst_ready", {30'd0, mem_ready, ex_ready}, 32'd3);
        tick();

        // Random traffic with a small register range to provoke forwarding hits
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 59) == 0,
                  $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
